// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin merge of PORTS AXI-stream inputs onto one output
// through a registered output stage with a one-entry skid buffer.
module axis_rr_arbiter #(
  parameter int PORTS       = 4,
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_WIDTH    = $clog2(PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS-1:0]              s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          busy
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  user;
    logic [ID_WIDTH-1:0]   id;
  } beat_t;
  state_t state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d, last_q, last_d, pick, idx;
  logic int_ready_q, int_ready_d, m_valid_q, m_valid_d, temp_valid_q, temp_valid_d;
  logic accept, to_main, to_temp, temp_to_main;
  logic [DATA_WIDTH-1:0] tdata_a [PORTS];
  logic [KEEP_WIDTH-1:0] tkeep_a [PORTS];
  beat_t in_beat, main_q, temp_q;
  for (genvar g = 0; g < PORTS; g++) begin : g_split
    assign tdata_a[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign tkeep_a[g] = s_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH];
  end
  assign accept  = state_q == ACTIVE && int_ready_q && s_axis_tvalid[grant_q];
  assign in_beat = '{data: tdata_a[grant_q], keep: tkeep_a[grant_q], last: s_axis_tlast[grant_q],
                     user: s_axis_tuser[grant_q], id: grant_q};
  assign s_axis_tready = (state_q == ACTIVE && int_ready_q) ? PORTS'(1) << grant_q : '0;
  assign busy          = state_q == ACTIVE;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = main_q.data;
  assign m_axis_tkeep  = KEEP_ENABLE ? main_q.keep : '1;
  assign m_axis_tlast  = main_q.last;
  assign m_axis_tuser  = main_q.user;
  assign m_axis_tid    = main_q.id;
  // Downward scan so the nearest requester above last_q is written last and wins.
  always_comb begin
    pick = grant_q;
    idx  = '0;
    for (int k = PORTS; k >= 1; k--) begin
      idx = ID_WIDTH'((int'(last_q) + k) % PORTS);
      if (s_axis_tvalid[idx]) pick = idx;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (state_q == IDLE && |s_axis_tvalid) begin
      state_d = ACTIVE;
      grant_d = pick;
    end
    if (accept && s_axis_tlast[grant_q]) begin
      state_d = IDLE;
      last_d  = grant_q;
    end
  end
  // Upstream ready is registered, so a beat may land in temp while main is stalled.
  always_comb begin
    m_valid_d    = m_valid_q;
    temp_valid_d = temp_valid_q;
    to_main      = 1'b0;
    to_temp      = 1'b0;
    temp_to_main = 1'b0;
    int_ready_d  = m_axis_tready || (!temp_valid_q && (!m_valid_q || !accept));
    if (int_ready_q) begin
      if (m_axis_tready || !m_valid_q) begin
        m_valid_d = accept;
        to_main   = 1'b1;
      end else begin
        temp_valid_d = accept;
        to_temp      = 1'b1;
      end
    end else if (m_axis_tready) begin
      m_valid_d    = temp_valid_q;
      temp_valid_d = 1'b0;
      temp_to_main = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= ID_WIDTH'(PORTS - 1);
      int_ready_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      temp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      int_ready_q  <= int_ready_d;
      m_valid_q    <= m_valid_d;
      temp_valid_q <= temp_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (to_main) main_q <= in_beat;
    else if (temp_to_main) main_q <= temp_q;
    if (to_temp) temp_q <= in_beat;
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed and random stimulus against a packet-level round-robin
// reference model with a beat scoreboard.
module tb_axis_rr_arbiter;
  localparam int P = 4, DW = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [P*DW-1:0] s_tdata;
  logic [P-1:0] s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DW-1:0] m_tdata;
  logic m_tkeep, m_tvalid, m_tready, m_tlast, m_tuser, busy;
  logic [1:0] m_tid;
  int total = 0, bad = 0, cyc_n = 0;
  logic [9:0] mem [P][64];
  int head [P], tail [P];
  logic [P-1:0] hold;
  int mode;
  bit busy_m;
  int gnt_m, last_m;
  logic [11:0] exp_q[$], out_beat[$];
  int out_cyc[$];
  int e29 [5] = '{0, 1, 2, 3, 0};
  int c0;

  axis_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .m_axis_tid(m_tid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      if (mode == 2) hold[p] = ($urandom_range(3) == 0);
      s_tvalid[p] = head[p] < tail[p] && !hold[p];
      {s_tuser[p], s_tlast[p], s_tdata[p*DW +: DW]} = mem[p][head[p]];
    end
    m_tready = mode == 0 ? 1'b1 : mode == 1 ? ~m_tready : 1'($urandom_range(2) != 0);
  endtask

  task automatic load(input int p, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      mem[p][tail[p]] = {1'($urandom_range(1)), k == n - 1, 8'(base + k)};
      tail[p]++;
    end
  endtask

  function automatic bit pending();
    for (int p = 0; p < P; p++) if (head[p] < tail[p]) return 1'b1;
    return exp_q.size() != 0 || busy_m;
  endfunction

  // One clock: check against the model at the negedge, account for the handshakes the
  // coming posedge will complete, then advance.
  task automatic cyc();
    logic [P-1:0] mask;
    bit found;
    drive();
    mask = busy_m ? P'(1) << gnt_m : '0;
    chk("busy", 32'(busy), 32'(busy_m));
    chk("tready_only_granted", 32'(s_tready & ~mask), 0);
    chk("m_tvalid_vs_pending", 32'(m_tvalid), 32'(exp_q.size() != 0));
    chk("buffer_depth_le2", 32'(exp_q.size() <= 2), 1);
    if (m_tvalid && m_tready && exp_q.size() != 0) begin
      chk("out_beat", {20'b0, m_tid, m_tuser, m_tlast, m_tdata}, {20'b0, exp_q[0]});
      out_beat.push_back({m_tid, m_tuser, m_tlast, m_tdata});
      out_cyc.push_back(cyc_n);
      void'(exp_q.pop_front());
    end
    if (!busy_m) begin
      found = 1'b0;
      for (int k = 1; k <= P; k++)
        if (!found && s_tvalid[(last_m + k) % P]) begin
          found = 1'b1;
          gnt_m = (last_m + k) % P;
        end
      busy_m = found;
    end else if (s_tvalid[gnt_m] && s_tready[gnt_m] && mem[gnt_m][head[gnt_m]][8]) begin
      busy_m = 1'b0;
      last_m = gnt_m;
    end
    for (int p = 0; p < P; p++)
      if (s_tvalid[p] && s_tready[p]) begin
        exp_q.push_back({2'(p), mem[p][head[p]]});
        head[p]++;
      end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_within_budget", 32'(n < budget), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mode  = 0;
    hold  = '0;
    for (int p = 0; p < P; p++) begin
      head[p] = 0;
      tail[p] = 0;
    end
    busy_m = 1'b0;
    gnt_m  = 0;
    last_m = P - 1;
    exp_q.delete();
    out_beat.delete();
    out_cyc.delete();
    drive();
    @(negedge clk);
    chk("reset_m_tvalid", 32'(m_tvalid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_tready", 32'(s_tready), 0);
    chk("reset_tkeep", 32'(m_tkeep), 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    s_tkeep  = '1;
    m_tready = 1'b1;
    // All four ports with 3-beat packets, port 0 twice.
    do_reset();
    load(0, 3, 8'h00); load(0, 3, 8'h08);
    load(1, 3, 8'h10); load(2, 3, 8'h20); load(3, 3, 8'h30);
    drain(200);
    chk("rr_beats", out_beat.size(), 15);
    for (int j = 0; j < 5; j++) chk("rr_order", 32'(out_beat[3*j][11:10]), e29[j]);
    chk("rr_span", out_cyc[14] - out_cyc[0], 18);
    // Port 2 alone: latency and back-to-back beats.
    do_reset();
    load(2, 4, 8'hA0);
    c0 = cyc_n;
    cyc();
    chk("p2_tready_next", 32'(s_tready), 32'b0100);
    drain(50);
    chk("p2_count", out_beat.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("p2_cycle", out_cyc[k], c0 + 2 + k);
      chk("p2_beat", {out_beat[k][11:10], out_beat[k][8:0]}, {2'd2, k == 3, 8'(8'hA0 + k)});
    end
    // Port 1, toggling m_axis_tready.
    do_reset();
    mode = 1;
    m_tready = 1'b0;
    load(1, 8, 8'h10);
    drain(100);
    chk("toggle_count", out_beat.size(), 8);
    for (int k = 0; k < 8; k++)
      chk("toggle_data", {out_beat[k][11:10], out_beat[k][7:0]}, {2'd1, 8'(8'h10 + k)});
    // Port 0 stalls mid-packet while port 3 waits.
    do_reset();
    load(0, 5, 8'h30);
    load(3, 2, 8'h40);
    repeat (3) cyc();
    hold[0] = 1'b1;
    repeat (3) cyc();
    chk("stall_no_beats", head[0], 2);
    chk("stall_p3_waits", head[3], 0);
    hold[0] = 1'b0;
    drain(100);
    chk("stall_count", out_beat.size(), 7);
    for (int k = 0; k < 7; k++) chk("stall_tid", 32'(out_beat[k][11:10]), k < 5 ? 0 : 3);
    // Reset mid-packet, then port 0 must win first.
    do_reset();
    load(2, 5, 8'h50);
    for (int n = 0; n < 20 && head[2] < 2; n++) cyc();
    chk("rst_reach_beat2", head[2], 2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_tvalid", 32'(m_tvalid), 0);
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_tready", 32'(s_tready), 0);
    do_reset();
    load(2, 3, 8'h70);
    load(0, 3, 8'h60);
    c0 = cyc_n;
    drain(100);
    chk("rst_first_tid", 32'(out_beat[0][11:10]), 0);
    chk("rst_first_cycle", out_cyc[0], c0 + 2);
    // Single-beat packets on ports 1 and 3.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      load(1, 1, 8'(8'h80 + j));
      load(3, 1, 8'(8'h90 + j));
    end
    drain(100);
    chk("single_count", out_beat.size(), 8);
    for (int k = 0; k < 8; k++) chk("single_tid", 32'(out_beat[k][11:10]), k % 2 == 0 ? 1 : 3);
    chk("single_span", out_cyc[7] - out_cyc[0], 14);
    // Random packets, gaps and backpressure.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      mode = 2;
      for (int p = 0; p < P; p++)
        for (int j = 0; j < 4; j++) load(p, $urandom_range(4, 1), 8'($urandom));
      drain(2000);
      chk("random_all_out", out_beat.size(), tail[0] + tail[1] + tail[2] + tail[3]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
